// File: rtl/lcd_cmd_engine.sv
// Command engine for an HD44780-style LCD: strobes one byte out as one 8-bit or two 4-bit transfers.
// Optional macro LCD_LONG_CMD_EN stretches the execution wait to T_LONG for clear/home commands.
module lcd_cmd_engine #(
  parameter int unsigned BUS_WIDTH = 4,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 12,
  parameter int unsigned T_GAP     = 50,
  parameter int unsigned T_WAIT    = 2000,
  parameter int unsigned T_LONG    = 82000,
  parameter int unsigned CNT_W     = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 rs_in,
  input  logic                 rw_in,
  input  logic [7:0]           data_in,
  output logic                 busy,
  output logic                 done,
  output logic                 lcd_rs,
  output logic                 lcd_rw,
  output logic                 lcd_e,
  output logic [BUS_WIDTH-1:0] sf_d
);

  localparam longint unsigned TMax = 64'd1 << CNT_W;

  if (!(BUS_WIDTH == 4 || BUS_WIDTH == 8)) begin : g_bad_width
    $error("lcd_cmd_engine: BUS_WIDTH must be 4 or 8");
  end
  if (T_SETUP < 1 || T_PULSE < 1 || T_GAP < 1 || T_WAIT < 1 || T_LONG < 1 ||
      T_SETUP >= TMax || T_PULSE >= TMax || T_GAP >= TMax || T_WAIT >= TMax ||
      T_LONG >= TMax) begin : g_bad_timing
    $error("lcd_cmd_engine: timing parameter out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LimSetup = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LimPulse = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LimGap   = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] LimWait  = CNT_W'(T_WAIT - 1);
`ifdef LCD_LONG_CMD_EN
  localparam logic [CNT_W-1:0] LimLong  = CNT_W'(T_LONG - 1);
`endif

  typedef enum logic [2:0] {
    StIdle, StSetup, StStrobe1, StGap, StStrobe2, StWait
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, lim, wait_lim;
  logic                 rs_q, rs_d, rw_q, rw_d;
  logic [7:0]           data_q, data_d;
  logic                 busy_q, busy_d, done_q, done_d, e_q, e_d;
  logic                 lcd_rs_q, lcd_rs_d, lcd_rw_q, lcd_rw_d, drive;
  logic [BUS_WIDTH-1:0] sf_q, sf_next;

  always_comb begin
`ifdef LCD_LONG_CMD_EN
    wait_lim = (!rs_q && !rw_q && (data_q == 8'h01 || data_q == 8'h02)) ? LimLong : LimWait;
`else
    wait_lim = LimWait;
`endif
    lim = '0;
    case (state_q)
      StSetup:              lim = LimSetup;
      StStrobe1, StStrobe2: lim = LimPulse;
      StGap:                lim = LimGap;
      StWait:               lim = wait_lim;
      default:              lim = '0;
    endcase

    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    data_d  = data_q;
    if (state_q == StIdle) begin
      if (start) begin
        state_d = StSetup;
        cnt_d   = '0;
        rs_d    = rs_in;
        rw_d    = rw_in;
        data_d  = data_in;
      end
    end else if (cnt_q == lim) begin
      cnt_d = '0;
      case (state_q)
        StSetup:   state_d = StStrobe1;
        StStrobe1: state_d = (BUS_WIDTH == 8) ? StWait : StGap;
        StGap:     state_d = StStrobe2;
        StStrobe2: state_d = StWait;
        default:   state_d = StIdle;
      endcase
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs are derived from the next state so the registered pins line up with state_q.
    busy_d   = (state_d != StIdle);
    e_d      = (state_d == StStrobe1) || (state_d == StStrobe2);
    drive    = (state_d == StSetup) || (state_d == StStrobe1) ||
               (state_d == StGap) || (state_d == StStrobe2);
    lcd_rs_d = drive & rs_d;
    lcd_rw_d = drive & rw_d;
    done_d   = (state_d == StWait) && (cnt_d == wait_lim);
    case (state_d)
      StSetup, StStrobe1: sf_next = data_d[7 -: BUS_WIDTH];
      StGap, StStrobe2:   sf_next = data_d[BUS_WIDTH-1:0];
      default:            sf_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      e_q      <= 1'b0;
      lcd_rs_q <= 1'b0;
      lcd_rw_q <= 1'b0;
      sf_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rs_q     <= rs_d;
      rw_q     <= rw_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      e_q      <= e_d;
      lcd_rs_q <= lcd_rs_d;
      lcd_rw_q <= lcd_rw_d;
      sf_q     <= sf_next;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign lcd_e  = e_q;
  assign lcd_rs = lcd_rs_q;
  assign lcd_rw = lcd_rw_q;
  assign sf_d   = sf_q;

endmodule

// File: tb/tb_lcd_cmd_engine.sv
// Directed bench: one 4-bit and one 8-bit engine, short timings, cycle-exact pin checks.
module tb_lcd_cmd_engine;

  logic       clk = 1'b0;
  logic       rst, start4, start8, rs_in, rw_in;
  logic [7:0] data_in;
  logic       busy4, done4, rs4, rw4, e4;
  logic [3:0] sf4;
  logic       busy8, done8, rs8, rw8, e8;
  logic [7:0] sf8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lcd_cmd_engine #(
    .BUS_WIDTH(4), .T_SETUP(2), .T_PULSE(3), .T_GAP(4), .T_WAIT(5), .T_LONG(20), .CNT_W(17)
  ) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .rs_in(rs_in), .rw_in(rw_in), .data_in(data_in),
    .busy(busy4), .done(done4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_e(e4), .sf_d(sf4)
  );

  lcd_cmd_engine #(
    .BUS_WIDTH(8), .T_SETUP(2), .T_PULSE(3), .T_GAP(4), .T_WAIT(5), .T_LONG(20), .CNT_W(17)
  ) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .rs_in(rs_in), .rw_in(rw_in), .data_in(data_in),
    .busy(busy8), .done(done8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_e(e8), .sf_d(sf8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input bit wide, input string tag);
    check({tag, " busy"}, wide ? busy8 : busy4, 0);
    check({tag, " done"}, wide ? done8 : done4, 0);
    check({tag, " e"},    wide ? e8 : e4, 0);
    check({tag, " rs"},   wide ? rs8 : rs4, 0);
    check({tag, " rw"},   wide ? rw8 : rw4, 0);
    check({tag, " sf"},   wide ? sf8 : {4'h0, sf4}, 0);
  endtask

  // Called during an IDLE cycle; returns at the negedge of the IDLE cycle after done.
  task automatic run_cmd(input bit wide, input logic rs, input logic rw, input logic [7:0] d,
                         input bit disturb);
    int         w, total;
    logic [7:0] hi, lo, exp_sf;
    logic       exp_e, drv;
    string      tag;
    w = 5;
`ifdef LCD_LONG_CMD_EN
    if (!rs && !rw && (d == 8'h01 || d == 8'h02)) w = 20;
`endif
    total = wide ? (2 + 3 + w) : (2 + 3 + 4 + 3 + w);
    hi = wide ? d : {4'h0, d[7:4]};
    lo = {4'h0, d[3:0]};
    rs_in = rs; rw_in = rw; data_in = d;
    if (wide) start8 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; start8 = 1'b0;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i < 2)                     begin exp_e = 0; exp_sf = hi; drv = 1; end
      else if (i < 5)                begin exp_e = 1; exp_sf = hi; drv = 1; end
      else if (!wide && i < 9)       begin exp_e = 0; exp_sf = lo; drv = 1; end
      else if (!wide && i < 12)      begin exp_e = 1; exp_sf = lo; drv = 1; end
      else                           begin exp_e = 0; exp_sf = 0;  drv = 0; end
      tag = $sformatf("%s d=%02h rs=%0d c%0d", wide ? "w8" : "w4", d, rs, i);
      check({tag, " busy"}, wide ? busy8 : busy4, 1);
      check({tag, " done"}, wide ? done8 : done4, (i == total - 1) ? 1 : 0);
      check({tag, " e"},    wide ? e8 : e4, exp_e);
      check({tag, " rs"},   wide ? rs8 : rs4, drv & rs);
      check({tag, " rw"},   wide ? rw8 : rw4, drv & rw);
      check({tag, " sf"},   wide ? sf8 : {4'h0, sf4}, exp_sf);
      if (disturb && (i == 3 || i == total - 2)) begin
        if (wide) start8 = 1'b1; else start4 = 1'b1;
        data_in = ~d; rs_in = ~rs; rw_in = ~rw;
      end
      if (disturb && (i == 6 || i == total - 1)) begin
        start4 = 1'b0; start8 = 1'b0;
      end
    end
    @(negedge clk);
    check_idle(wide, $sformatf("%s d=%02h after", wide ? "w8" : "w4", d));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0; rs_in = 1'b0; rw_in = 1'b0; data_in = 8'h00;
    @(negedge clk);
    check_idle(0, "reset w4");
    check_idle(1, "reset w8");
    // start during reset must be ignored
    start4 = 1'b1; rs_in = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    check_idle(0, "start in reset");
    rst = 1'b0;
    start4 = 1'b0;

    run_cmd(0, 1'b1, 1'b0, 8'hA5, 0);
    run_cmd(1, 1'b0, 1'b0, 8'h3C, 0);
    run_cmd(1, 1'b1, 1'b1, 8'h81, 0);

    // Mid-command start/data changes, then confirm no queued restart.
    run_cmd(0, 1'b1, 1'b1, 8'h96, 1);
    @(negedge clk);
    check_idle(0, "no requeue");
    // Back-to-back: second start lands in the IDLE cycle right after done.
    run_cmd(0, 1'b0, 1'b0, 8'h5A, 0);
    run_cmd(0, 1'b1, 1'b0, 8'hC3, 0);

    // Asynchronous reset during STROBE1.
    rs_in = 1'b1; rw_in = 1'b1; data_in = 8'hF0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset strobe e", e4, 1);
    check("pre-reset busy", busy4, 1);
    #2 rst = 1'b1;
    #1 check_idle(0, "async reset");
    @(negedge clk);
    rst = 1'b0;
    check_idle(0, "post reset");
    run_cmd(0, 1'b1, 1'b0, 8'h4E, 0);

    // Clear/home commands: long wait only with the macro and rs=rw=0.
    run_cmd(0, 1'b0, 1'b0, 8'h01, 0);
    run_cmd(0, 1'b1, 1'b0, 8'h01, 0);
    run_cmd(1, 1'b0, 1'b0, 8'h02, 0);
    run_cmd(1, 1'b0, 1'b0, 8'h03, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
